// File: rtl/proc_control_fsm.sv
// Instruction-sequencing control for the 16-bit processor: walks T0..T5.
// Optional trap on illegal opcodes: define PROC_CTRL_ILLEGAL_TRAP_EN.
module proc_control_fsm #(
    parameter logic [3:0] SEL_PC  = 4'd7,
    parameter logic [3:0] SEL_IMM = 4'd8,
    parameter logic [3:0] SEL_G   = 4'd9,
    parameter logic [3:0] SEL_DIN = 4'd10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    input  logic [15:0] ir,
    output logic [3:0]  mux_sel,
    output logic [7:0]  r_in,
    output logic        ir_in,
    output logic        a_in,
    output logic        g_in,
    output logic [1:0]  alu_op,
    output logic        addr_in,
    output logic        dout_in,
    output logic        w_d,
    output logic        pc_incr,
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    output logic        illegal,
`endif
    output logic        done
);

    localparam logic [2:0] T0   = 3'd0;
    localparam logic [2:0] T1   = 3'd1;
    localparam logic [2:0] T2   = 3'd2;
    localparam logic [2:0] T3   = 3'd3;
    localparam logic [2:0] T4   = 3'd4;
    localparam logic [2:0] T5   = 3'd5;
    localparam logic [2:0] HALT = 3'd6;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_LD  = 3'b100;
    localparam logic [2:0] OP_ST  = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;

    logic [2:0] state;
    logic [2:0] state_nxt;

    logic [2:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       imm_f;
    logic [3:0] operand;
    logic [7:0] rx_hot;
    logic       trap;

    assign opcode  = ir[15:13];
    assign rx      = ir[12:10];
    assign imm_f   = ir[9];
    assign ry      = ir[2:0];
    assign operand = imm_f ? SEL_IMM : {1'b0, ry};
    assign rx_hot  = 8'd1 << rx;

`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Reserved opcode, or mvt without the immediate flag, traps in T3
    assign trap = (state == T3) &&
                  ((opcode == 3'b111) || (opcode == OP_MVT && !imm_f));
    assign illegal = illegal_q | trap;

    // Sticky illegal flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!resetn)
            illegal_q <= 1'b0;
        else if (trap)
            illegal_q <= 1'b1;
    end
`else
    assign trap = 1'b0;
`endif

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn)
            state <= T0;
        else
            state <= state_nxt;
    end

    // Next-state and control outputs decoded from state and ir
    always_comb begin
        mux_sel   = 4'd0;
        r_in      = 8'd0;
        ir_in     = 1'b0;
        a_in      = 1'b0;
        g_in      = 1'b0;
        alu_op    = 2'b00;
        addr_in   = 1'b0;
        dout_in   = 1'b0;
        w_d       = 1'b0;
        pc_incr   = 1'b0;
        done      = 1'b0;
        state_nxt = state;
        case (state)
            T0: begin
                if (run) begin
                    mux_sel   = SEL_PC;
                    addr_in   = 1'b1;
                    pc_incr   = 1'b1;
                    state_nxt = T1;
                end
            end
            T1: state_nxt = T2;
            T2: begin
                ir_in     = 1'b1;
                state_nxt = T3;
            end
            T3: begin
                if (trap) begin
                    state_nxt = HALT;
                end else begin
                    case (opcode)
                        OP_MV: begin
                            mux_sel   = operand;
                            r_in      = rx_hot;
                            done      = 1'b1;
                            state_nxt = T0;
                        end
                        OP_MVT: begin
                            if (imm_f) begin
                                mux_sel = SEL_IMM;
                                r_in    = rx_hot;
                            end
                            done      = 1'b1;
                            state_nxt = T0;
                        end
                        OP_ADD, OP_SUB, OP_AND: begin
                            mux_sel   = {1'b0, rx};
                            a_in      = 1'b1;
                            state_nxt = T4;
                        end
                        OP_LD, OP_ST: begin
                            mux_sel   = {1'b0, ry};
                            addr_in   = 1'b1;
                            state_nxt = T4;
                        end
                        default: begin
                            done      = 1'b1;
                            state_nxt = T0;
                        end
                    endcase
                end
            end
            T4: begin
                state_nxt = T5;
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND: begin
                        mux_sel = operand;
                        g_in    = 1'b1;
                        if (opcode == OP_SUB)
                            alu_op = 2'b01;
                        else if (opcode == OP_AND)
                            alu_op = 2'b10;
                    end
                    OP_ST: begin
                        mux_sel   = {1'b0, rx};
                        dout_in   = 1'b1;
                        w_d       = 1'b1;
                        done      = 1'b1;
                        state_nxt = T0;
                    end
                    default: ;
                endcase
            end
            T5: begin
                mux_sel   = (opcode == OP_LD) ? SEL_DIN : SEL_G;
                r_in      = rx_hot;
                done      = 1'b1;
                state_nxt = T0;
            end
            default: begin
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
                state_nxt = HALT;
`else
                state_nxt = T0;
`endif
            end
        endcase
    end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Self-checking bench for proc_control_fsm.
// Expected cycle-by-cycle output lists are built from the instruction rules.
module tb_proc_control_fsm;

    logic        clk;
    logic        resetn;
    logic        run;
    logic [15:0] ir;
    logic [3:0]  mux_sel;
    logic [7:0]  r_in;
    logic        ir_in;
    logic        a_in;
    logic        g_in;
    logic [1:0]  alu_op;
    logic        addr_in;
    logic        dout_in;
    logic        w_d;
    logic        pc_incr;
    logic        done;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int checks;
    int failures;

    logic [21:0] exp_q[$];
    logic [21:0] obs;

    proc_control_fsm dut (
        .clk(clk),
        .resetn(resetn),
        .run(run),
        .ir(ir),
        .mux_sel(mux_sel),
        .r_in(r_in),
        .ir_in(ir_in),
        .a_in(a_in),
        .g_in(g_in),
        .alu_op(alu_op),
        .addr_in(addr_in),
        .dout_in(dout_in),
        .w_d(w_d),
        .pc_incr(pc_incr),
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        .illegal(illegal),
`endif
        .done(done)
    );

    assign obs = {mux_sel, r_in, ir_in, a_in, g_in, alu_op,
                  addr_in, dout_in, w_d, pc_incr, done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack one cycle's expected outputs
    function automatic logic [21:0] v(
        input logic [3:0] m, input logic [7:0] r,
        input logic iri, input logic ai, input logic gi,
        input logic [1:0] op, input logic ad, input logic dn,
        input logic wd, input logic pc, input logic dd);
        return {m, r, iri, ai, gi, op, ad, dn, wd, pc, dd};
    endfunction

    // Expected output list for one whole instruction
    task automatic plan(input logic [15:0] i);
        logic [2:0] op;
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] opnd;
        logic [7:0] xh;
        logic [1:0] aop;
        op   = i[15:13];
        x    = {1'b0, i[12:10]};
        y    = {1'b0, i[2:0]};
        opnd = i[9] ? 4'd8 : y;
        xh   = 8'd1 << i[12:10];
        aop  = (op == 3'd2) ? 2'd0 : (op == 3'd3) ? 2'd1 : 2'd2;
        exp_q.delete();
        exp_q.push_back(v(4'd7, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        case (op)
            3'd0: exp_q.push_back(v(opnd, xh, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            3'd1: begin
                if (i[9])
                    exp_q.push_back(v(4'd8, xh, 0, 0, 0, 0, 0, 0, 0, 0, 1));
                else
                    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            end
            3'd2, 3'd3, 3'd6: begin
                exp_q.push_back(v(x, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(v(opnd, 0, 0, 0, 1, aop, 0, 0, 0, 0, 0));
                exp_q.push_back(v(4'd9, xh, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            end
            3'd4: begin
                exp_q.push_back(v(y, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
                exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(v(4'd10, xh, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            end
            3'd5: begin
                exp_q.push_back(v(y, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
                exp_q.push_back(v(x, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
            end
            default: exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        endcase
    endtask

    // Check outputs mid-cycle, then advance to the next negedge
    task automatic cyc(input string tag, input logic [21:0] e);
        #1;
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, e);
        end
        @(negedge clk);
    endtask

    task automatic run_instr(input string tag, input logic [15:0] i);
        int n;
        plan(i);
        ir  = i;
        run = 1'b1;
        n   = 0;
        while (exp_q.size() > 0) begin
            if (n > 0)
                run = 1'($urandom_range(0, 1));
            cyc($sformatf("%s_%h_c%0d", tag, i, n), exp_q.pop_front());
            n++;
        end
    endtask

    function automatic logic [15:0] rand_ir();
        logic [15:0] i;
        i = 16'($urandom);
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        while (i[15:13] == 3'b111 || (i[15:13] == 3'b001 && !i[9]))
            i = 16'($urandom);
`endif
        return i;
    endfunction

    initial begin
        logic [15:0] dir[6];
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        run      = 1'b0;
        ir       = 16'h0000;

        @(negedge clk);
        @(negedge clk);
        cyc("reset", 22'd0);
        resetn = 1'b1;
        for (int k = 0; k < 5; k++)
            cyc($sformatf("idle%0d", k), 22'd0);

        dir[0] = 16'h1205;
        dir[1] = 16'h4402;
        dir[2] = 16'h8803;
        dir[3] = 16'hA803;
        dir[4] = 16'h1C00;
        dir[5] = 16'h7C85;
        for (int k = 0; k < 6; k++)
            run_instr("dir", dir[k]);

        // Abort an add during T4
        plan(16'h4402);
        ir  = 16'h4402;
        run = 1'b1;
        for (int k = 0; k < 4; k++)
            cyc($sformatf("abort_c%0d", k), exp_q.pop_front());
        resetn = 1'b0;
        cyc("abort_t4", exp_q.pop_front());
        resetn = 1'b1;
        run    = 1'b0;
        for (int k = 0; k < 3; k++)
            cyc($sformatf("abort_post%0d", k), 22'd0);

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                run = 1'b0;
                ir  = 16'($urandom);
                cyc("rand_idle", 22'd0);
            end else begin
                run_instr("rand", rand_ir());
            end
        end

`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        plan(16'hE000);
        ir  = 16'hE000;
        run = 1'b1;
        for (int k = 0; k < 3; k++)
            cyc($sformatf("ill_c%0d", k), exp_q.pop_front());
        #1;
        checks++;
        assert (illegal === 1'b1) else begin
            failures++;
            $error("FAIL ill_t3 obs=%b exp=1", illegal);
        end
        cyc("ill_t3_out", 22'd0);
        for (int k = 0; k < 4; k++) begin
            cyc($sformatf("halt%0d", k), 22'd0);
            checks++;
            assert (illegal === 1'b1) else begin
                failures++;
                $error("FAIL halt_ill obs=%b exp=1", illegal);
            end
        end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        run    = 1'b0;
        #1;
        checks++;
        assert (illegal === 1'b0) else begin
            failures++;
            $error("FAIL ill_clear obs=%b exp=0", illegal);
        end
        cyc("ill_idle", 22'd0);
        run_instr("post_ill", 16'h1205);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/proc_control_fsm.md
Name: proc_control_fsm

Overview:
- Instruction-sequencing control unit for the 16-bit enhanced processor.
- Sits directly upstream of the bus multiplexer: drives its 4-bit select and all register, ALU and memory-interface enables.
- Walks each instruction through timesteps T0..T5 and pulses done on completion.
- Decodes the instruction register: opcode [15:13], rX [12:10], imm flag [9], rY [2:0], immediate [8:0].

Parameters:
- SEL_PC, 4'd7: mux select for r7 (program counter).
- SEL_IMM, 4'd8: mux select for the immediate path (mux applies the MVT shift itself).
- SEL_G, 4'd9: mux select for the ALU result register G.
- SEL_DIN, 4'd10: mux select for memory read data.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- run  in  1  level enable; fetch starts only while high.
- ir  in  16  current instruction register contents.
- mux_sel  out  4  bus multiplexer select.
- r_in  out  8  one-hot load enables for r0..r7.
- ir_in  out  1  instruction register load.
- a_in  out  1  ALU A-operand register load.
- g_in  out  1  G register load.
- alu_op  out  2  00 add, 01 sub, 10 and.
- addr_in  out  1  memory address register load.
- dout_in  out  1  memory write-data register load.
- w_d  out  1  memory write enable.
- pc_incr  out  1  r7 increment.
- done  out  1  single-cycle instruction-complete pulse.

Behaviour:
Clocking and reset
- Interface: one clock (clk); reset is synchronous and active-low (resetn).
- resetn=0 at a rising edge: state := T0.
- In T0 with run=0, all outputs are 0, so the post-reset values of all outputs are 0.
- Reset mid-instruction abandons the instruction. No partial writes occur after that edge.

Output rules
- Outputs are combinational from the state register and ir.
- Any output not listed for a state is 0. mux_sel defaults to 0.
- operand = (ir[9] ? SEL_IMM : {1'b0, rY}).

States
- T0: if run=1: mux_sel=SEL_PC, addr_in=1, pc_incr=1, next T1. Else remain in T0.
- T1: memory latency wait, no outputs; next T2.
- T2: ir_in=1; next T3.

Per-opcode sequences from T3
- mv (000), T3: mux_sel=operand, r_in[rX]=1, done=1, next T0.
- mvt (001), T3: mux_sel=SEL_IMM, r_in[rX]=1, done=1, next T0.
- add/sub/and (010/011/110):
  - T3: mux_sel=rX, a_in=1.
  - T4: mux_sel=operand, g_in=1, alu_op=00/01/10 respectively.
  - T5: mux_sel=SEL_G, r_in[rX]=1, done=1, next T0.
- ld (100):
  - T3: mux_sel=rY, addr_in=1.
  - T4: wait.
  - T5: mux_sel=SEL_DIN, r_in[rX]=1, done=1.
- st (101):
  - T3: mux_sel=rY, addr_in=1.
  - T4: mux_sel=rX, dout_in=1, w_d=1, done=1, next T0.
- reserved (111), T3: no-op, done=1, next T0.

Latency
- mv/mvt: 4 cycles.
- st: 5 cycles.
- alu/ld: 6 cycles.
- Back-to-back: the next T0 follows immediately after the done cycle if run=1.

Boundary conditions
- run sampled only in T0. Deasserting run mid-instruction does not stop that instruction.
- rX=7 writes the PC through r_in[7]. No pc_incr in that cycle.
- ir must be stable from T3 until done.
- r_in is always one-hot or zero.

Optional Feature:
- Macro: PROC_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output illegal (1 bit).
  - Opcode 111 at T3, or mvt with ir[9]=0 at T3, sets illegal=1 (sticky) and moves to state HALT.
  - HALT: all other outputs 0. Left only by resetn=0, which clears illegal.
- Undefined: both cases act as a no-op with done; no illegal port exists.

Test Plan:
- Reset/idle: resetn=0 for 2 cycles, then resetn=1 with run=0 for 5 cycles -> every output 0, state stays T0.
- mv immediate: run=1, ir=16'h1205 (mv r4,#5) -> T0 mux_sel=7, addr_in=1, pc_incr=1; T2 ir_in=1; T3 mux_sel=8, r_in=8'h10, done=1; 4 cycles total.
- add register: ir=16'h4402 (add r1,r2) -> T3 mux_sel=1, a_in; T4 mux_sel=2, g_in, alu_op=00; T5 mux_sel=9, r_in=8'h02, done.
- ld/st: ir=16'h8803 (ld r2,[r3]) -> T3 mux_sel=3, addr_in; T5 mux_sel=10, r_in=8'h04, done. ir=16'hA803 (st r2,[r3]) -> T4 mux_sel=2, dout_in=1, w_d=1, done.
- Reset mid-instruction: assert resetn=0 during T4 of an add -> the next cycle is T0 with all outputs 0, and no g_in or r_in pulses follow.
- Illegal (macro on): ir=16'hE000 -> at T3 illegal=1, all later outputs 0 despite run=1; resetn=0 clears illegal.
